// File: rtl/branch_sequencer.sv
// Multi-cycle next-PC controller for the jump/branch path.
//
// Accepts one decoded branch/jump op at a time, resolves it against the status
// flags and owns the PC register. jm fetches its target through a memory read
// handshake (with timeout to a trap vector); balz writes the link register and
// spends one extra cycle in LINK.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   op_valid / op_ready  op handshake, transfer = op_valid & op_ready
//   bnj                  op code (000 none, 001 j, 010 beq, 011 bgez, 100 brn,
//                        101 jm, 110 balz, 111 none)
//   stat                 flags: [1] zero, [0] negative
//   imm16, jidx, rs_val  branch offset (words), jump index, register operand
//   pc, taken            current PC; pulse when the last op redirected PC
//   mem_req/addr/ack/rdata  jm target read handshake
//   link_we, link_data   link register write strobe and return address
//   fault                pulse on jm memory timeout
module branch_sequencer #(
  parameter int unsigned WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(32'h8000_0180),
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       bnj,
  input  logic [1:0]       stat,
  input  logic [15:0]      imm16,
  input  logic [25:0]      jidx,
  input  logic [WIDTH-1:0] rs_val,
  output logic [WIDTH-1:0] pc,
  output logic             taken,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             link_we,
  output logic [WIDTH-1:0] link_data,
  output logic             fault
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [2:0] OpNone = 3'b000;
  localparam logic [2:0] OpJ    = 3'b001;
  localparam logic [2:0] OpBeq  = 3'b010;
  localparam logic [2:0] OpBgez = 3'b011;
  localparam logic [2:0] OpBrn  = 3'b100;
  localparam logic [2:0] OpJm   = 3'b101;
  localparam logic [2:0] OpBalz = 3'b110;
  localparam logic [2:0] OpNop7 = 3'b111;

  typedef enum logic [1:0] {StIdle, StMemWait, StLink} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic              taken_q, taken_d;
  logic              mem_req_q, mem_req_d;
  logic [WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic              link_we_q, link_we_d;
  logic [WIDTH-1:0]  link_data_q, link_data_d;
  logic              fault_q, fault_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]  pc_plus4;
  logic [WIDTH-1:0]  imm_sext;
  logic [WIDTH-1:0]  boff;
  logic [WIDTH-1:0]  pc_br;
  logic [WIDTH-1:0]  pc_jmp;
  logic              transfer;
  logic              tmo_expired;

  assign pc_plus4    = pc_q + WIDTH'(4);
  assign imm_sext    = {{(WIDTH - 16){imm16[15]}}, imm16};
  assign boff        = {imm_sext[WIDTH-3:0], 2'b00};
  assign pc_br       = pc_plus4 + boff;
  // Region-relative jump: keep the top nibble of pc+4, splice in the index.
  assign pc_jmp      = {pc_plus4[WIDTH-1:28], jidx, 2'b00};
  assign transfer    = op_valid & op_ready;
  // cnt_q holds the number of completed mem_req cycles before this one.
  assign tmo_expired = (cnt_q == CntW'(MEM_TIMEOUT - 1));

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      taken_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      link_we_q   <= 1'b0;
      link_data_q <= '0;
      fault_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      taken_q     <= taken_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      link_we_q   <= link_we_d;
      link_data_q <= link_data_d;
      fault_q     <= fault_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (transfer) begin
          if (bnj == OpJm) begin
            state_d = StMemWait;
          end else if (bnj == OpBalz && stat[1]) begin
            state_d = StLink;
          end
        end
      end
      StMemWait: begin
        if (mem_ack || tmo_expired) begin
          state_d = StIdle;
        end
      end
      StLink:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the PC and the registered outputs.
  always_comb begin
    pc_d        = pc_q;
    taken_d     = 1'b0;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    link_we_d   = 1'b0;
    link_data_d = link_data_q;
    fault_d     = 1'b0;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (transfer) begin
          pc_d = pc_plus4;
          unique case (bnj)
            OpJ: begin
              pc_d    = pc_jmp;
              taken_d = 1'b1;
            end
            OpBeq: begin
              if (stat[1]) begin
                pc_d    = pc_br;
                taken_d = 1'b1;
              end
            end
            OpBgez: begin
              if (!stat[0]) begin
                pc_d    = pc_br;
                taken_d = 1'b1;
              end
            end
            OpBrn: begin
              if (stat[0]) begin
                pc_d    = rs_val;
                taken_d = 1'b1;
              end
            end
            OpJm: begin
              pc_d       = pc_q;
              mem_addr_d = rs_val + imm_sext;
              mem_req_d  = 1'b1;
              cnt_d      = '0;
            end
            OpBalz: begin
              if (stat[1]) begin
                pc_d        = pc_jmp;
                taken_d     = 1'b1;
                link_we_d   = 1'b1;
                link_data_d = pc_plus4;
              end
            end
            OpNone, OpNop7: begin
              pc_d = pc_plus4;
            end
            default: begin
              pc_d = pc_plus4;
            end
          endcase
        end
      end
      StMemWait: begin
        // An ack on the expiry edge takes priority over the trap.
        if (mem_ack) begin
          pc_d      = mem_rdata;
          taken_d   = 1'b1;
          mem_req_d = 1'b0;
        end else if (tmo_expired) begin
          pc_d      = TRAP_VECTOR;
          fault_d   = 1'b1;
          mem_req_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLink: begin
        pc_d = pc_q;
      end
      default: begin
        pc_d = pc_q;
      end
    endcase
  end

  // Outputs.
  always_comb begin
    op_ready  = (state_q == StIdle);
    pc        = pc_q;
    taken     = taken_q;
    mem_req   = mem_req_q;
    mem_addr  = mem_addr_q;
    link_we   = link_we_q;
    link_data = link_data_q;
    fault     = fault_q;
  end

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: table of single-op vectors (each
// preceded by a brn that loads the start PC) plus directed jm/reset sequences.
module tb_branch_sequencer;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  bnj;
  logic [1:0]  stat;
  logic [15:0] imm16;
  logic [25:0] jidx;
  logic [31:0] rs_val;
  logic [31:0] pc;
  logic        taken;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        link_we;
  logic [31:0] link_data;
  logic        fault;

  int checks = 0;
  int errors = 0;

  branch_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .bnj       (bnj),
    .stat      (stat),
    .imm16     (imm16),
    .jidx      (jidx),
    .rs_val    (rs_val),
    .pc        (pc),
    .taken     (taken),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .link_we   (link_we),
    .link_data (link_data),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  bnj;
    logic [1:0]  stat;
    logic [15:0] imm16;
    logic [25:0] jidx;
    logic [31:0] rs_val;
    logic [31:0] start_pc;
    logic [31:0] exp_pc;
    logic        exp_taken;
    logic        exp_link_we;
    logic [31:0] exp_link_data;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one op at the negedge, transfer on the next posedge, return #1 after it.
  task automatic do_op(input logic [2:0] b, input logic [1:0] s, input logic [15:0] im,
                       input logic [25:0] ji, input logic [31:0] rs);
    @(negedge clk);
    bnj      = b;
    stat     = s;
    imm16    = im;
    jidx     = ji;
    rs_val   = rs;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pc(input logic [31:0] target);
    do_op(3'b100, 2'b01, 16'h0, 26'h0, target);
  endtask

  initial begin
    int n;
    vecs[0]  = '{"none",        3'b000, 2'b00, 16'h0000, 26'h0,       32'h0,
                 32'h0000_0100, 32'h0000_0104, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{"j",           3'b001, 2'b00, 16'h0000, 26'h3FF_FFFF, 32'h0,
                 32'h1234_5678, 32'h1FFF_FFFC, 1'b1, 1'b0, 32'h0};
    vecs[2]  = '{"beq_taken",   3'b010, 2'b10, 16'h0004, 26'h0,       32'h0,
                 32'h0000_0100, 32'h0000_0114, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{"beq_not",     3'b010, 2'b00, 16'h0004, 26'h0,       32'h0,
                 32'h0000_0100, 32'h0000_0104, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{"bgez_not",    3'b011, 2'b01, 16'h0004, 26'h0,       32'h0,
                 32'h0000_0200, 32'h0000_0204, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{"bgez_back",   3'b011, 2'b00, 16'hFFFF, 26'h0,       32'h0,
                 32'h0000_0200, 32'h0000_0200, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{"brn_taken",   3'b100, 2'b01, 16'h0000, 26'h0,       32'hDEAD_BEE0,
                 32'h0000_0300, 32'hDEAD_BEE0, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{"brn_not",     3'b100, 2'b00, 16'h0000, 26'h0,       32'hDEAD_BEE0,
                 32'h0000_0300, 32'h0000_0304, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{"balz_taken",  3'b110, 2'b10, 16'h0000, 26'h10,      32'h0,
                 32'h0040_0010, 32'h0000_0040, 1'b1, 1'b1, 32'h0040_0014};
    vecs[9]  = '{"balz_not",    3'b110, 2'b00, 16'h0000, 26'h10,      32'h0,
                 32'h0000_0500, 32'h0000_0504, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{"op111",       3'b111, 2'b11, 16'h0004, 26'h10,      32'h0,
                 32'h0000_0600, 32'h0000_0604, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{"none_wrap",   3'b000, 2'b00, 16'h0000, 26'h0,       32'h0,
                 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 32'h0};
    vecs[12] = '{"beq_neg_wrap", 3'b010, 2'b10, 16'h8000, 26'h0,      32'h0,
                 32'h0000_0010, 32'hFFFE_0014, 1'b1, 1'b0, 32'h0};

    reset     = 1'b1;
    op_valid  = 1'b0;
    bnj       = 3'b000;
    stat      = 2'b00;
    imm16     = 16'h0;
    jidx      = 26'h0;
    rs_val    = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_pc", pc, 32'h0);
    check("rst_op_ready", 32'(op_ready), 32'h1);
    check("rst_taken", 32'(taken), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_link_we", 32'(link_we), 32'h0);
    check("rst_link_data", link_data, 32'h0);
    check("rst_fault", 32'(fault), 32'h0);

    // Table-driven single ops.
    for (int i = 0; i < 13; i++) begin
      load_pc(vecs[i].start_pc);
      check({vecs[i].name, "_preload"}, pc, vecs[i].start_pc);
      do_op(vecs[i].bnj, vecs[i].stat, vecs[i].imm16, vecs[i].jidx, vecs[i].rs_val);
      check({vecs[i].name, "_pc"}, pc, vecs[i].exp_pc);
      check({vecs[i].name, "_taken"}, 32'(taken), 32'(vecs[i].exp_taken));
      check({vecs[i].name, "_link_we"}, 32'(link_we), 32'(vecs[i].exp_link_we));
      if (vecs[i].exp_link_we) begin
        check({vecs[i].name, "_link_data"}, link_data, vecs[i].exp_link_data);
        check({vecs[i].name, "_ready_link"}, 32'(op_ready), 32'h0);
        step();
        check({vecs[i].name, "_ready_after"}, 32'(op_ready), 32'h1);
        check({vecs[i].name, "_pc_hold"}, pc, vecs[i].exp_pc);
      end else begin
        check({vecs[i].name, "_ready"}, 32'(op_ready), 32'h1);
      end
    end

    // mem_ack outside MEM_WAIT is ignored.
    load_pc(32'h0000_0700);
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555_0000;
    step();
    mem_ack = 1'b0;
    check("stray_ack_pc", pc, 32'h0000_0700);
    check("stray_ack_taken", 32'(taken), 32'h0);

    // jm acked in the 3rd mem_req cycle; ops offered meanwhile are dropped.
    do_op(3'b101, 2'b00, 16'h0008, 26'h0, 32'h0000_1000);
    check("jm_req", 32'(mem_req), 32'h1);
    check("jm_addr", mem_addr, 32'h0000_1008);
    check("jm_pc_hold", pc, 32'h0000_0700);
    check("jm_ready", 32'(op_ready), 32'h0);
    bnj      = 3'b001;
    jidx     = 26'h123;
    op_valid = 1'b1;
    repeat (2) step();
    op_valid  = 1'b0;
    check("jm_req_wait", 32'(mem_req), 32'h1);
    check("jm_addr_stable", mem_addr, 32'h0000_1008);
    check("jm_pc_wait", pc, 32'h0000_0700);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_2000;
    step();
    mem_ack = 1'b0;
    check("jm_ack_pc", pc, 32'h0000_2000);
    check("jm_ack_taken", 32'(taken), 32'h1);
    check("jm_ack_req", 32'(mem_req), 32'h0);
    check("jm_ack_ready", 32'(op_ready), 32'h1);
    step();
    check("jm_no_queue_pc", pc, 32'h0000_2000);

    // jm timeout: exactly 16 cycles of mem_req, then trap and fault pulse.
    do_op(3'b101, 2'b00, 16'hFFFC, 26'h0, 32'h0000_0040);
    check("tmo_addr", mem_addr, 32'h0000_003C);
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      step();
    end
    check("tmo_req_cycles", 32'(n), 32'd16);
    check("tmo_pc", pc, 32'h8000_0180);
    check("tmo_fault", 32'(fault), 32'h1);
    check("tmo_taken", 32'(taken), 32'h0);
    step();
    check("tmo_fault_pulse", 32'(fault), 32'h0);
    check("tmo_ready", 32'(op_ready), 32'h1);

    // Ack on the expiry edge wins over the trap.
    do_op(3'b101, 2'b00, 16'h0000, 26'h0, 32'h0000_3000);
    repeat (15) step();
    check("edge_req", 32'(mem_req), 32'h1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_4444;
    step();
    mem_ack = 1'b0;
    check("edge_pc", pc, 32'h0000_4444);
    check("edge_fault", 32'(fault), 32'h0);
    check("edge_taken", 32'(taken), 32'h1);

    // Reset in MEM_WAIT abandons the fetch.
    do_op(3'b101, 2'b00, 16'h0004, 26'h0, 32'h0000_5000);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstw_pc", pc, 32'h0);
    check("rstw_req", 32'(mem_req), 32'h0);
    check("rstw_ready", 32'(op_ready), 32'h1);
    check("rstw_addr", mem_addr, 32'h0);
    step();
    check("rstw_idle_pc", pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
